// File: rtl/game_pkg.sv
// Shared types and constants for the bird game controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int unsigned ROWS      = 8;
  localparam int unsigned START_ROW = 3;
  localparam int unsigned TOP_ROW   = 6;

  function automatic logic [ROWS-1:0] row_onehot(input int unsigned row);
    return ROWS'(1) << row;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running step counter; step is high for one cycle at CYCLES-1 while enabled.
module step_timer #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count;

  assign step = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/bird_flight_ctrl.sv
// Game-flow controller: bird movement, column pacing, collision, score and game FSM.
// Optional macro AUTOPILOT_EN selects ai_push as push source when ai_mode is high.
module bird_flight_ctrl
  import game_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter int unsigned COL_STEPS   = 4,
  parameter int unsigned CRASH_STEPS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            push_btn,
  input  logic            ai_mode,
  input  logic            ai_push,
  input  logic [ROWS-1:0] obstacle,
  output logic [ROWS-1:0] bird_tail,
  output logic [ROWS-1:0] bird_head,
  output logic            col_advance,
  output logic [7:0]      score,
  output logic            running,
  output logic            game_over
);

  localparam int unsigned COL_W   = (COL_STEPS > 1) ? $clog2(COL_STEPS) : 1;
  localparam int unsigned CRASH_W = (CRASH_STEPS > 1) ? $clog2(CRASH_STEPS) : 1;
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COL_STEPS - 1);
  localparam logic [CRASH_W-1:0] CRASH_LAST = CRASH_W'(CRASH_STEPS - 1);
  localparam logic [ROWS-1:0]    START_POS  = row_onehot(START_ROW);

  state_t             state, next_state;
  logic [ROWS-1:0]    tail;
  logic [COL_W-1:0]   col_cnt;
  logic [CRASH_W-1:0] crash_cnt;
  logic               push_eff, push_prev, push_edge, push_latch, push_now;
  logic               step, hit, ground, timer_en, timer_clr;

`ifdef AUTOPILOT_EN
  assign push_eff = ai_mode ? ai_push : push_btn;
`else
  logic unused_ai;
  assign unused_ai = ai_mode ^ ai_push;
  assign push_eff  = push_btn;
`endif

  assign push_edge = push_eff && !push_prev;
  // An edge arriving in the step cycle itself still counts for that step.
  assign push_now  = push_latch || push_edge;

  assign bird_tail = tail;
  assign bird_head = {tail[ROWS-2:0], 1'b0};

  assign hit    = (state == RUN) && ((obstacle & (bird_tail | bird_head)) != '0);
  assign ground = step && tail[0] && !push_now;

  assign timer_en  = (state == RUN) || (state == CRASH);
  assign timer_clr = (next_state != state);

  step_timer #(
    .CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk (clk),
    .rst (reset),
    .en  (timer_en),
    .clr (timer_clr),
    .step(step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = RUN;
      RUN:   if (hit || ground) next_state = CRASH;
      CRASH: if (step && (crash_cnt == CRASH_LAST)) next_state = OVER;
      OVER:  if (start) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    running   = 1'b0;
    game_over = 1'b0;
    unique case (state)
      RUN:     running   = 1'b1;
      OVER:    game_over = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail        <= START_POS;
      score       <= '0;
      col_advance <= 1'b0;
      col_cnt     <= '0;
      crash_cnt   <= '0;
      push_latch  <= 1'b0;
      push_prev   <= 1'b0;
    end else begin
      col_advance <= 1'b0;
      push_prev   <= push_eff;
      unique case (state)
        IDLE, OVER: begin
          if (start) begin
            tail       <= START_POS;
            score      <= '0;
            col_cnt    <= '0;
            crash_cnt  <= '0;
            push_latch <= 1'b0;
          end
        end
        RUN: begin
          crash_cnt <= '0;
          // A collision freezes everything for the cycle; the FSM takes it to CRASH.
          if (!hit) begin
            if (step) begin
              push_latch <= 1'b0;
              if (!ground) begin
                if (push_now) begin
                  if (!tail[TOP_ROW]) tail <= tail << 1;
                end else begin
                  tail <= tail >> 1;
                end
                if (col_cnt == COL_LAST) begin
                  col_cnt     <= '0;
                  col_advance <= 1'b1;
                  if ((obstacle != '0) && (score != 8'hFF)) score <= score + 8'd1;
                end else begin
                  col_cnt <= col_cnt + COL_W'(1);
                end
              end
            end else if (push_edge) begin
              push_latch <= 1'b1;
            end
          end
        end
        CRASH: begin
          if (step) crash_cnt <= crash_cnt + CRASH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bird_flight_ctrl.sv
// Directed self-checking bench for bird_flight_ctrl (STEP_CYCLES=4, COL_STEPS=2, CRASH_STEPS=2).
module tb_bird_flight_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       push_btn;
  logic       ai_mode;
  logic       ai_push;
  logic [7:0] obstacle;
  logic [7:0] bird_tail;
  logic [7:0] bird_head;
  logic       col_advance;
  logic [7:0] score;
  logic       running;
  logic       game_over;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  bird_flight_ctrl #(
    .STEP_CYCLES(4),
    .COL_STEPS  (2),
    .CRASH_STEPS(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .push_btn   (push_btn),
    .ai_mode    (ai_mode),
    .ai_push    (ai_push),
    .obstacle   (obstacle),
    .bird_tail  (bird_tail),
    .bird_head  (bird_head),
    .col_advance(col_advance),
    .score      (score),
    .running    (running),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full game step from timer count 0; optional push pulse in its first cycle.
  task automatic do_step(input logic p);
    push_btn = p;
    tick(1);
    push_btn = 1'b0;
    tick(3);
  endtask

  task automatic do_step_ai(input logic p);
    ai_push = p;
    tick(1);
    ai_push = 1'b0;
    tick(3);
  endtask

  task automatic new_game(input logic [7:0] obs);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    obstacle = obs;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; push_btn = 1'b0;
    ai_mode = 1'b0; ai_push = 1'b0; obstacle = 8'h00;
    #12;
    check("rst_tail", bird_tail, 8'h08);
    check("rst_head", bird_head, 8'h10);
    check("rst_score", score, 8'd0);
    check("rst_running", running, 1'b0);
    check("rst_over", game_over, 1'b0);
    check("rst_col", col_advance, 1'b0);
    reset = 1'b0;
    tick(1);
    check("idle_hold", running, 1'b0);

    // Free fall to the ground, then CRASH for 2 steps into OVER.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("run_enter", running, 1'b1);
    tick(3);
    check("no_early_step", bird_tail, 8'h08);
    tick(1);
    check("fall1_tail", bird_tail, 8'h04);
    check("fall1_col", col_advance, 1'b0);
    do_step(1'b0);
    check("fall2_tail", bird_tail, 8'h02);
    check("fall2_col", col_advance, 1'b1);
    tick(1);
    check("col_one_cycle", col_advance, 1'b0);
    tick(3);
    check("fall3_tail", bird_tail, 8'h01);
    do_step(1'b0);
    check("ground_tail", bird_tail, 8'h01);
    check("ground_running", running, 1'b0);
    check("ground_score", score, 8'd0);
    start = 1'b1;
    tick(7);
    check("crash_not_over", game_over, 1'b0);
    check("crash_ignore_start", running, 1'b0);
    start = 1'b0;
    tick(1);
    check("over", game_over, 1'b1);

    // Restart from OVER and climb with pushes, saturating at row 6.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("restart_running", running, 1'b1);
    check("restart_tail", bird_tail, 8'h08);
    do_step(1'b1);
    check("climb4", bird_tail, 8'h10);
    do_step(1'b1);
    check("climb5", bird_tail, 8'h20);
    do_step(1'b1);
    check("climb6", bird_tail, 8'h40);
    do_step(1'b1);
    check("climb_sat_tail", bird_tail, 8'h40);
    check("climb_sat_head", bird_head, 8'h80);
    check("climb_running", running, 1'b1);
    check("climb_score_zero_obs", score, 8'd0);

    // Pass walls through the gap (rows 2-4) by alternating push.
    new_game(8'hE3);
    do_step(1'b0);
    check("gap_s1_tail", bird_tail, 8'h04);
    check("gap_s1_col", col_advance, 1'b0);
    do_step(1'b1);
    check("gap_s2_tail", bird_tail, 8'h08);
    check("gap_s2_col", col_advance, 1'b1);
    check("gap_s2_score", score, 8'd1);
    do_step(1'b0);
    do_step(1'b1);
    check("gap_s4_score", score, 8'd2);
    check("gap_running", running, 1'b1);

    // Wall appears on the bird's rows.
    obstacle = 8'h18;
    tick(1);
    check("hit_running", running, 1'b0);
    check("hit_score", score, 8'd2);
    check("hit_tail", bird_tail, 8'h08);
    check("hit_col", col_advance, 1'b0);

    // Reset mid-run at score 5.
    new_game(8'hE3);
    for (int i = 0; i < 5; i++) begin
      do_step(1'b0);
      do_step(1'b1);
    end
    check("score5", score, 8'd5);
    #2 reset = 1'b1;
    #1;
    check("async_tail", bird_tail, 8'h08);
    check("async_head", bird_head, 8'h10);
    check("async_score", score, 8'd0);
    check("async_running", running, 1'b0);
    reset = 1'b0;
    tick(1);
    check("after_rst_idle", running, 1'b0);

    // Score saturation.
    new_game(8'hE3);
    for (int i = 0; i < 255; i++) begin
      do_step(1'b0);
      do_step(1'b1);
    end
    check("score255", score, 8'd255);
    do_step(1'b0);
    do_step(1'b1);
    check("score_sat", score, 8'd255);
    check("score_sat_col", col_advance, 1'b1);

    // Push source selection.
    new_game(8'h00);
    ai_mode = 1'b1;
    do_step_ai(1'b1);
`ifdef AUTOPILOT_EN
    check("ai_climb", bird_tail, 8'h10);
`else
    check("ai_ignored", bird_tail, 8'h04);
`endif
    ai_mode = 1'b0;
    do_step_ai(1'b1);
`ifdef AUTOPILOT_EN
    check("ai_off_fall", bird_tail, 8'h08);
`else
    check("ai_off_fall", bird_tail, 8'h02);
`endif
    tick(3);
    push_btn = 1'b1;
    tick(1);
    push_btn = 1'b0;
`ifdef AUTOPILOT_EN
    check("edge_on_step", bird_tail, 8'h10);
`else
    check("edge_on_step", bird_tail, 8'h04);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bird_flight_ctrl.md
# bird_flight_ctrl

Game-flow controller for the 8-row bird column. Sequences each game step: chooses the push source (button or autopilot), moves the bird up or down one row, tells the obstacle generator when to shift columns, detects collisions, keeps the score and runs the start/crash/game-over state machine. Sits between the input debouncer, the autopilot push logic, the obstacle generator and the display driver.

## Interface
- STEP_CYCLES, 50_000_000: clock cycles per game step (≥2)
- COL_STEPS, 4: game steps per obstacle-column advance (≥1)
- CRASH_STEPS, 8: steps spent in CRASH before OVER (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  level; starts or restarts a game
- push_btn  in  1  debounced player button, level
- ai_mode  in  1  1 = autopilot drives push (autopilot build only)
- ai_push  in  1  autopilot push request, level
- obstacle  in  8  current column at bird x-position; bit i = 1 is wall in row i
- bird_tail  out  8  one-hot lower bird row
- bird_head  out  8  one-hot upper bird row, always bird_tail << 1
- col_advance  out  1  one-cycle strobe: obstacle generator shifts one column
- score  out  8  columns passed, saturates at 255
- running  out  1  high in RUN
- game_over  out  1  high in OVER

## Operation
- Reset values: state IDLE, tail row 3 (bird_tail 8'h08, bird_head 8'h10), score 0, col_advance 0, running 0, game_over 0, step and column counters 0, push latch 0.
- States: IDLE, RUN, CRASH, OVER.
- IDLE: bird held at row 3; start=1 → RUN, counters cleared.
- RUN: step timer runs. Push rising edge (effective push source) sets push latch; latch cleared at each step. At each step: latch set → tail row +1, saturating at row 6; latch clear → tail row −1; at row 0 with no push → CRASH (ground hit), position unchanged.
- Column counter increments per step; when reaching COL_STEPS−1 it wraps and col_advance pulses in the same cycle as the step update. On that pulse, if obstacle ≠ 0 and no collision this cycle, score +1 (saturating).
- Collision: every RUN cycle, (obstacle & (bird_tail | bird_head)) ≠ 0 → CRASH next cycle; no move, no score in the collision cycle.
- CRASH: bird frozen; after CRASH_STEPS steps → OVER.
- OVER: game_over=1; start=1 → RUN with bird at row 3, score 0, counters 0.
- start ignored in RUN and CRASH.
- Simultaneous push edge and step: edge counts for that step.

## Timing
- All outputs registered; position, score, state update on the clock edge ending the step cycle.
- Step cycle = step counter at STEP_CYCLES−1; first step STEP_CYCLES cycles after entering RUN.
- col_advance exactly one cycle wide, coincident with step update.
- Collision → state CRASH one cycle later; running falls same edge.
- Reset asserted mid-game: all state returns to reset values immediately (asynchronous); release resumes in IDLE.

## Configuration
- AUTOPILOT_EN defined: effective push = ai_mode ? ai_push : push_btn.
- Not defined: effective push = push_btn; ai_mode and ai_push present but ignored.

## Structure
- game_pkg: state enum (IDLE, RUN, CRASH, OVER), ROWS=8, START_ROW=3, TOP_ROW=6.
- Sub-module step_timer: counter of STEP_CYCLES with enable and synchronous clear, emitting one-cycle step pulse; one instance.

## Test plan
Use STEP_CYCLES=4, COL_STEPS=2, CRASH_STEPS=2.
- Reset, start=1, no push, obstacle=0 → tail rows 2,1,0 at steps 1–3; step 4 → CRASH; 8 cycles later game_over=1.
- RUN, push_btn pulse before each step, obstacle=0 → tail climbs 4,5,6,6; never crashes.
- obstacle=8'hE3 (gap rows 2–4), bird row 3, alternating push → col_advance every 8 cycles, score increments each strobe, no crash.
- obstacle changes to 8'h18 while tail row 3 → CRASH next cycle, score unchanged, running=0.
- AUTOPILOT_EN, ai_mode=1, ai_push pulses, push_btn held 0 → bird climbs; ai_mode=0 → falls; without macro ai_push has no effect.
- Reset asserted mid-RUN at score 5 → outputs immediately 8'h08/8'h10/score 0/IDLE; score 255 plus another pass → stays 255.
